// File: rtl/draw_pkg.sv
// Shared types and helpers for the block draw sequencer.
// Holds the sequencer state encoding and tile geometry math.
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAW,
        DONE
    } draw_state_e;

    localparam int DEF_BG_COLOR = 0;

    // Tile origin in pixels; 32 bits wide so nothing is lost before compare.
    function automatic logic [31:0] tile_origin(
        input logic [31:0] col,
        input int          shift
    );
        return col << shift;
    endfunction

endpackage

// File: rtl/block_raster_counter.sv
// Two-dimensional raster counter, inner index fastest.
// Reused for the full-screen clear and for single tile draws.
module block_raster_counter #(
    parameter int IW = 10,
    parameter int OW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [IW-1:0] inner_max,
    input  logic [OW-1:0] outer_max,
    output logic [IW-1:0] inner,
    output logic [OW-1:0] outer,
    output logic          last
);

    logic [IW-1:0] inner_q, inner_d;
    logic [OW-1:0] outer_q, outer_d;

    // Next position: restart at origin on load, else step inner then outer.
    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        if (load) begin
            inner_d = '0;
            outer_d = '0;
        end else if (en) begin
            if (inner_q == inner_max) begin
                inner_d = '0;
                if (outer_q == outer_max) begin
                    outer_d = '0;
                end else begin
                    outer_d = outer_q + OW'(1);
                end
            end else begin
                inner_d = inner_q + IW'(1);
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end

    assign inner = inner_q;
    assign outer = outer_q;
    assign last  = (inner_q == inner_max) && (outer_q == outer_max);

endmodule

// File: rtl/block_draw_sequencer.sv
// Single sequencer owning the pixel write port: optional clear,
// then up to MAX_BLOCKS square tiles, one pixel per cycle.
module block_draw_sequencer
    import draw_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int X_W        = 10,
    parameter int Y_W        = 9,
    parameter int COLOR_W    = 1,
    parameter int BG_COLOR   = DEF_BG_COLOR,
    parameter int BLOCK_LOG2 = 3,
    parameter int MAX_BLOCKS = 16,
    parameter int IDX_W      = $clog2(MAX_BLOCKS),
    parameter int N_W        = $clog2(MAX_BLOCKS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               clear_en,
    input  logic [N_W-1:0]     n_blocks,
    output logic [IDX_W-1:0]   blk_idx,
    input  logic [X_W-1:0]     blk_col,
    input  logic [Y_W-1:0]     blk_row,
    input  logic [COLOR_W-1:0] blk_color,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_we,
    output logic               busy,
    output logic               done
);

    localparam int B = 1 << BLOCK_LOG2;

    draw_state_e        state_q, state_d;
    logic [N_W-1:0]     n_q, n_d;
    logic [N_W-1:0]     idx_q, idx_d;
    logic [X_W-1:0]     px0_q, px0_d;
    logic [Y_W-1:0]     py0_q, py0_d;
    logic [COLOR_W-1:0] col_q, col_d;

    logic [N_W-1:0]     n_clamp;
    logic [N_W-1:0]     idx_inc;
    logic               idx_last;
    logic [31:0]        px_wide;
    logic [31:0]        py_wide;
    logic               tile_off;

    logic               cnt_load;
    logic               cnt_en;
    logic [X_W-1:0]     cnt_inner_max;
    logic [Y_W-1:0]     cnt_outer_max;
    logic [X_W-1:0]     cnt_inner;
    logic [Y_W-1:0]     cnt_outer;
    logic               cnt_last;

    logic [X_W:0]       draw_x;
    logic [Y_W:0]       draw_y;

    assign n_clamp = (n_blocks > N_W'(MAX_BLOCKS)) ? N_W'(MAX_BLOCKS)
                                                   : n_blocks;
    assign idx_inc  = idx_q + N_W'(1);
    assign idx_last = (idx_inc == n_q);

    assign px_wide  = tile_origin(32'(blk_col), BLOCK_LOG2);
    assign py_wide  = tile_origin(32'(blk_row), BLOCK_LOG2);
    assign tile_off = (px_wide >= 32'(SCREEN_W)) ||
                      (py_wide >= 32'(SCREEN_H));

    assign cnt_load      = (state_q == IDLE) || (state_q == FETCH);
    assign cnt_en        = (state_q == CLEAR) || (state_q == DRAW);
    assign cnt_inner_max = (state_q == DRAW) ? X_W'(B - 1)
                                             : X_W'(SCREEN_W - 1);
    assign cnt_outer_max = (state_q == DRAW) ? Y_W'(B - 1)
                                             : Y_W'(SCREEN_H - 1);

    block_raster_counter #(
        .IW (X_W),
        .OW (Y_W)
    ) u_raster (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .en        (cnt_en),
        .inner_max (cnt_inner_max),
        .outer_max (cnt_outer_max),
        .inner     (cnt_inner),
        .outer     (cnt_outer),
        .last      (cnt_last)
    );

    // Frame sequencing: latch request, walk clear raster and tile list.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        px0_d   = px0_q;
        py0_d   = py0_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d   = n_clamp;
                    idx_d = '0;
                    if (clear_en) begin
                        state_d = CLEAR;
                    end else if (n_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            CLEAR: begin
                if (cnt_last) begin
                    state_d = (n_q == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                px0_d = px_wide[X_W-1:0];
                py0_d = py_wide[Y_W-1:0];
                col_d = blk_color;
                if (tile_off) begin
                    idx_d   = idx_inc;
                    state_d = idx_last ? DONE : FETCH;
                end else begin
                    state_d = DRAW;
                end
            end
            DRAW: begin
                if (cnt_last) begin
                    idx_d   = idx_inc;
                    state_d = idx_last ? DONE : FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            px0_q   <= '0;
            py0_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            px0_q   <= px0_d;
            py0_q   <= py0_d;
            col_q   <= col_d;
        end
    end

    assign draw_x = {1'b0, px0_q} + {1'b0, cnt_inner};
    assign draw_y = {1'b0, py0_q} + {1'b0, cnt_outer};

    // Pixel port decoded purely from registered state and counters.
    always_comb begin
        x           = '0;
        y           = '0;
        pixel_color = '0;
        pixel_we    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                x           = cnt_inner;
                y           = cnt_outer;
                pixel_color = COLOR_W'(BG_COLOR);
                pixel_we    = 1'b1;
            end
            DRAW: begin
                x           = draw_x[X_W-1:0];
                y           = draw_y[Y_W-1:0];
                pixel_color = col_q;
                pixel_we    = (draw_x < (X_W+1)'(SCREEN_W)) &&
                              (draw_y < (Y_W+1)'(SCREEN_H));
            end
            default: begin
                pixel_we = 1'b0;
            end
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign blk_idx = idx_q[IDX_W-1:0];

endmodule

// File: tb/tb_block_draw_sequencer.sv
// Scoreboard bench for block_draw_sequencer on a 15x8 screen
// with 2x2 tiles and up to four tiles per frame.
module tb_block_draw_sequencer;

    localparam int SW = 15;
    localparam int SH = 8;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear_en;
    logic [2:0] n_blocks;
    logic [1:0] blk_idx;
    logic [4:0] blk_col;
    logic [3:0] blk_row;
    logic       blk_color;
    logic [4:0] x;
    logic [3:0] y;
    logic       pixel_color;
    logic       pixel_we;
    logic       busy;
    logic       done;

    logic [4:0] t_col [MB];
    logic [3:0] t_row [MB];
    logic       t_clr [MB];

    int checks   = 0;
    int failures = 0;

    int exp_wx  [$];
    int exp_wy  [$];
    int exp_wc  [$];
    int exp_idx [$];
    int exp_len [$];

    bit in_frame = 1'b0;
    int cyc      = 0;
    int last_idx = -1;

    block_draw_sequencer #(
        .SCREEN_W   (SW),
        .SCREEN_H   (SH),
        .X_W        (5),
        .Y_W        (4),
        .COLOR_W    (1),
        .BG_COLOR   (0),
        .BLOCK_LOG2 (1),
        .MAX_BLOCKS (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .clear_en    (clear_en),
        .n_blocks    (n_blocks),
        .blk_idx     (blk_idx),
        .blk_col     (blk_col),
        .blk_row     (blk_row),
        .blk_color   (blk_color),
        .x           (x),
        .y           (y),
        .pixel_color (pixel_color),
        .pixel_we    (pixel_we),
        .busy        (busy),
        .done        (done)
    );

    assign blk_col   = t_col[blk_idx];
    assign blk_row   = t_row[blk_idx];
    assign blk_color = t_clr[blk_idx];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: frame contents straight from the tile list.
    task automatic build_expect(input bit clr, input int n);
        int ne;
        int on;
        int px;
        int py;
        ne = (n > MB) ? MB : n;
        on = 0;
        if (clr) begin
            for (int yy = 0; yy < SH; yy++) begin
                for (int xx = 0; xx < SW; xx++) begin
                    exp_wx.push_back(xx);
                    exp_wy.push_back(yy);
                    exp_wc.push_back(0);
                end
            end
        end
        for (int i = 0; i < ne; i++) begin
            exp_idx.push_back(i);
            px = int'(t_col[i]) * 2;
            py = int'(t_row[i]) * 2;
            if (px < SW && py < SH) begin
                on++;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        if (px + dx < SW && py + dy < SH) begin
                            exp_wx.push_back(px + dx);
                            exp_wy.push_back(py + dy);
                            exp_wc.push_back(int'(t_clr[i]));
                        end
                    end
                end
            end
        end
        exp_len.push_back((clr ? SW * SH : 0) + ne + on * 4 + 1);
    endtask

    task automatic flush_expect();
        exp_wx.delete();
        exp_wy.delete();
        exp_wc.delete();
        exp_idx.delete();
        exp_len.delete();
    endtask

    task automatic start_frame(input bit clr, input int n);
        build_expect(clr, n);
        start    = 1'b1;
        clear_en = clr;
        n_blocks = 3'(n);
        tick();
        start    = 1'b0;
        clear_en = 1'($urandom);
        n_blocks = 3'($urandom);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        chk("frame_timeout", int'(busy), 0);
        chk("idle_done", int'(done), 0);
        chk("writes_left", exp_wx.size(), 0);
        chk("idx_left", exp_idx.size(), 0);
        chk("len_left", exp_len.size(), 0);
    endtask

    task automatic set_tile(input int i, input int c, input int r,
                            input bit k);
        t_col[i] = 5'(c);
        t_row[i] = 4'(r);
        t_clr[i] = k;
    endtask

    task automatic rand_tiles();
        for (int i = 0; i < MB; i++) begin
            set_tile(i, $urandom_range(0, 9), $urandom_range(0, 5),
                     1'($urandom));
        end
    endtask

    // Observes every cycle and checks against the scoreboard queues.
    task automatic monitor();
        int ex;
        int ey;
        int ec;
        forever begin
            @(negedge clk);
            if (pixel_we) begin
                if (exp_wx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL write_extra x=%0d y=%0d c=%0d", x, y,
                             pixel_color);
                end else begin
                    ex = exp_wx.pop_front();
                    ey = exp_wy.pop_front();
                    ec = exp_wc.pop_front();
                    chk("write_x", int'(x), ex);
                    chk("write_y", int'(y), ey);
                    chk("write_c", int'(pixel_color), ec);
                end
            end
            if (in_frame) begin
                cyc++;
                if (busy && !pixel_we && !done &&
                    int'(blk_idx) != last_idx) begin
                    last_idx = int'(blk_idx);
                    if (exp_idx.size() == 0) begin
                        chk("idx_extra", last_idx, -1);
                    end else begin
                        chk("blk_idx", last_idx, exp_idx.pop_front());
                    end
                end
                if (done) begin
                    chk("busy_at_done", int'(busy), 1);
                    if (exp_len.size() == 0) begin
                        chk("len_extra", cyc, -1);
                    end else begin
                        chk("frame_len", cyc, exp_len.pop_front());
                    end
                    in_frame = 1'b0;
                end else if (!busy) begin
                    chk("busy_early_drop", int'(busy), 1);
                    in_frame = 1'b0;
                end
            end else if (done) begin
                chk("done_unexpected", int'(done), 0);
            end
            if (reset) begin
                in_frame = 1'b0;
            end else if (start && !busy) begin
                in_frame = 1'b1;
                cyc      = 0;
                last_idx = -1;
            end
        end
    endtask

    task automatic driver();
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        clear_en = 1'b0;
        n_blocks = '0;
        for (int i = 0; i < MB; i++) begin
            set_tile(i, 0, 0, 1'b0);
        end
        repeat (3) tick();
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_color", int'(pixel_color), 0);
        chk("rst_we", int'(pixel_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_idx", int'(blk_idx), 0);
        reset = 1'b0;
        tick();

        // full clear, no tiles
        start_frame(1'b1, 0);
        wait_frame();

        // single on-screen tile
        set_tile(0, 3, 2, 1'b1);
        start_frame(1'b0, 1);
        wait_frame();

        // off-screen tile skipped, right-edge tile clipped
        set_tile(0, 8, 0, 1'b1);
        set_tile(1, 7, 3, 1'b1);
        start_frame(1'b0, 2);
        wait_frame();

        // tile count clamped to the maximum
        rand_tiles();
        start_frame(1'b0, 6);
        wait_frame();

        // start while busy is ignored
        for (int i = 0; i < MB; i++) begin
            set_tile(i, i, i, 1'b1);
        end
        start_frame(1'b0, 4);
        repeat (3) tick();
        start    = 1'b1;
        clear_en = 1'b1;
        n_blocks = 3'd1;
        repeat (2) tick();
        start = 1'b0;
        wait_frame();

        // reset during a tile draw
        start_frame(1'b0, 2);
        k = 0;
        while (!pixel_we && k < 50) begin
            tick();
            k++;
        end
        chk("reach_draw", int'(pixel_we), 1);
        reset = 1'b1;
        tick();
        flush_expect();
        reset = 1'b0;
        chk("midrst_we", int'(pixel_we), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        rand_tiles();
        start_frame(1'b1, 3);
        wait_frame();

        // start coincident with reset stays idle
        start    = 1'b1;
        clear_en = 1'b1;
        n_blocks = 3'd2;
        reset    = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rststart_busy", int'(busy), 0);
            chk("rststart_we", int'(pixel_we), 0);
            tick();
        end

        // randomized frames
        for (int f = 0; f < 16; f++) begin
            rand_tiles();
            start_frame(($urandom_range(0, 3) == 0),
                        $urandom_range(0, 6));
            wait_frame();
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        fork
            monitor();
            driver();
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_draw_sequencer.md
Name: block_draw_sequencer

Overview:
Parametrised successor to the snake-game print path. The old path muxed a screen-clear raster and a fixed snake-block writer onto the VGA pixel port. This block owns the pixel-write port with a single sequencer. On each start it optionally clears the screen to a background colour, then draws up to MAX_BLOCKS square tiles (snake segments, food, walls), one pixel per cycle. Tile geometry, colour depth, screen size and tile count are parameters; tile data is fetched from the parent through an index/lookup interface.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
COLOR_W, 1, pixel colour width
BG_COLOR, 0, colour written during clear
BLOCK_LOG2, 3, tile edge = 2**BLOCK_LOG2 pixels
MAX_BLOCKS, 16, maximum tiles per frame; IDX_W = $clog2(MAX_BLOCKS), N_W = $clog2(MAX_BLOCKS+1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
clear_en  in  1  clear the screen before drawing tiles; latched at start
n_blocks  in  N_W  number of tiles this frame; latched at start
blk_idx  out  IDX_W  index of the tile being fetched
blk_col  in  X_W  tile column, in tile units; combinational response to blk_idx
blk_row  in  Y_W  tile row, in tile units
blk_color  in  COLOR_W  tile colour
x  out  X_W  pixel x
y  out  Y_W  pixel y
pixel_color  out  COLOR_W  pixel colour
pixel_we  out  1  x/y/pixel_color valid; write this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: state=IDLE; x=0, y=0, pixel_color=0, pixel_we=0, busy=0, done=0, blk_idx=0. Reset overrides start in the same cycle.
- Outputs are driven directly from registered state and counters, so there is no combinational path from start.
- IDLE, start=1:
  - Latch clear_en and n_eff = min(n_blocks, MAX_BLOCKS); clear tile index.
  - Next state: CLEAR if clear_en; else DONE if n_eff==0; else FETCH.
  - busy=1 from the next cycle.
- CLEAR:
  - Raster x=0..SCREEN_W-1 (inner), y=0..SCREEN_H-1 (outer).
  - pixel_we=1 and pixel_color=BG_COLOR on every cycle; exactly SCREEN_W*SCREEN_H cycles.
  - First write is (0,0) in the cycle after start.
  - After the last pixel: FETCH, or DONE if n_eff==0.
- FETCH, 1 cycle:
  - pixel_we=0; blk_idx = current index.
  - Register px0 = blk_col<<BLOCK_LOG2, py0 = blk_row<<BLOCK_LOG2, and colour. Shift arithmetic uses X_W+BLOCK_LOG2 / Y_W+BLOCK_LOG2 bits; no truncation before the compare.
  - If px0>=SCREEN_W or py0>=SCREEN_H, skip the tile: index++, then DONE if index==n_eff, else FETCH.
  - Otherwise go to DRAW.
- DRAW:
  - 2**(2*BLOCK_LOG2) cycles; dx inner, dy outer.
  - x=px0+dx, y=py0+dy, pixel_color=latched colour.
  - pixel_we=1 only when x<SCREEN_W and y<SCREEN_H; clipped pixels still consume their cycle.
  - After the last pixel: index++, then DONE if index==n_eff, else FETCH.
- DONE, 1 cycle: done=1, busy=1, pixel_we=0. Next state IDLE, where busy=0.
- Frame length = 1 + (clear_en ? W*H : 0) + n_eff + (on-screen tiles)*B*B + 1 cycles, where B=2**BLOCK_LOG2.
- start while busy: ignored, no queueing.
- blk_* inputs are sampled only in FETCH.
- Reset mid-frame: IDLE on the next edge, pixel_we=0 the next cycle, latched data discarded.
- Overlapping tiles: last-drawn wins; the block does no arbitration.

Decomposition:
- Package draw_pkg holds:
  - the state enum {IDLE, CLEAR, FETCH, DRAW, DONE};
  - the default BG_COLOR;
  - the helper function tile_origin(col, shift).
- Sub-module block_raster_counter:
  - Parametrised 2-D counter with enable, load-origin, inner/outer limits and a last flag.
  - One instance is reused for both the CLEAR raster and the DRAW tile, loaded with screen or tile limits.

Test Plan (SCREEN_W=15, SCREEN_H=8, BLOCK_LOG2=1, MAX_BLOCKS=4, COLOR_W=1, BG_COLOR=0):
1. Reset, then start with clear_en=1, n_blocks=0 -> 120 writes of colour 0 in raster order (0,0),(1,0)..(14,7); done pulses in the 121st cycle after start; busy=1 for 121 cycles; then busy=0.
2. clear_en=0, n_blocks=1, tile col=3, row=2, colour=1 -> one FETCH cycle with blk_idx=0, then writes at (6,4),(7,4),(6,5),(7,5) with colour 1; done on the next cycle.
3. Two tiles: col=8,row=0 (off-screen) and col=7,row=3 -> first tile skipped with zero writes and only 1 cycle; second tile writes (14,6),(14,7) only; its x=15 cycles have pixel_we=0 but still take 4 DRAW cycles.
4. n_blocks=6 -> clamped to 4; blk_idx sequence 0,1,2,3; done follows the fourth tile.
5. start pulsed again mid-frame -> no effect on sequence or writes; reset asserted during DRAW -> next cycle pixel_we=0, busy=0, done=0; a new start then runs a full frame correctly.
6. start and reset asserted in the same cycle -> remains IDLE, no writes, busy=0.
